huff_pair_decoder: RTL and testbench
====================================

Name: huff_pair_decoder

Overview:
- Generic bit-serial Huffman pair decoder for the MP3 big_values region.
- Codebook is loaded at run time into an internal table, so one instance serves any table; linbits is selected per symbol.
- Consumes the serial bitstream from the bit reservoir and emits signed (x, y) pairs to the requantiser.
- Adds ready/valid backpressure, an error flag and a flush over the fixed-table, linbits-0 predecessor.

Parameters:
- MAX_BITS, 19, longest codeword length in bits.
- DEPTH, 256, codebook entries.
- MAX_LINBITS, 13, largest supported linbits.
- VAL_W, 16, output value width (signed).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- axiiv  in  1  input bit valid.
- axiid  in  1  input bit, stream order (first bit first).
- axiir  out  1  ready to accept bit.
- linbits  in  4  linbits for the symbol; sampled when the first code bit is accepted.
- flush  in  1  abort current symbol.
- tbl_we  in  1  codebook write strobe.
- tbl_clear  in  1  invalidate all entries.
- tbl_addr  in  $clog2(DEPTH)  entry index.
- tbl_len  in  5  code length, 1..MAX_BITS; 0 marks the entry invalid.
- tbl_code  in  MAX_BITS  code, right-aligned.
- tbl_x, tbl_y  in  4 each  decoded magnitudes 0..15.
- axiov  out  1  output pair valid.
- out_ready  in  1  downstream accepts pair.
- x_val, y_val  out  VAL_W each  signed decoded values.
- err  out  1  one-cycle pulse: no codeword matched within MAX_BITS.

Behaviour:
- Reset values: all entries invalid; state CODE; bit count 0; axiov=0, x_val=0, y_val=0, err=0, axiir=1.
- Bit transfer: a bit transfers when axiiv && axiir.
- axiir is 1 in CODE, XLIN, XSIGN, YLIN and YSIGN; it is 0 in OUT.
- CODE state:
  - Candidate = {code_reg, axiid}, length cnt+1.
  - Match = valid entry with len == cnt+1 and code == candidate, checked against all entries in the same cycle.
  - On multiple matches, the lowest index wins.
  - On match: latch x_abs, y_abs and linbits_l; clear cnt; go to the next state in the order XLIN, XSIGN, YLIN, YSIGN, OUT, skipping any state that does not apply. Zero bubble.
  - On no match: shift the bit into code_reg and increment cnt.
  - If cnt+1 == MAX_BITS with no match: err=1 for that cycle, clear code_reg and cnt, stay in CODE. The bit is consumed.
- XLIN: applies if x_abs==15 and linbits_l>0.
  - Shift in linbits_l bits, MSB first.
  - x_mag = 15 + lin.
- XSIGN: applies if x_mag != 0. One bit; 1 means negative.
- YLIN and YSIGN: same rules as XLIN and XSIGN, applied to y.
- A pair with x=y=0 goes straight from CODE to OUT on the matching bit.
- OUT state:
  - axiov=1; x_val and y_val are the two's-complement values, sign-extended to VAL_W. Max |value| is 15+8191=8206.
  - Outputs hold stable while axiov && !out_ready.
  - On out_ready: next cycle axiov=0 and state returns to CODE.
  - No bit is accepted in the cycle the pair is accepted.
  - x_val and y_val keep their last values while axiov=0.
- flush: takes priority over everything except rst.
  - Clears code_reg, cnt, linbits_l and the sign/lin accumulators.
  - Drops a pending output (axiov=0 next cycle); state goes to CODE.
  - The table is kept.
- Table writes:
  - Take effect the next cycle and are legal in any state.
  - A write in the same cycle as a match does not affect that match.
  - tbl_clear invalidates all entries next cycle; on simultaneous tbl_clear and tbl_we, tbl_clear wins.
- rst mid-symbol: everything returns to reset values, including the table.
- linbits > MAX_LINBITS: behaviour is undefined.

Test Plan:
- Load entries {len1 "1" → (0,0)}, {len3 "010" → (0,1)}, {len3 "011" → (1,0)}; stream 1 → axiov with (0,0) one cycle after the bit; err=0.
- Stream 0,1,1,1 → (-1,0); stream 0,1,0,0 → (0,+1). Each pair is emitted after its sign bit.
- Load {len2 "11" → (15,0)}, linbits=4; stream 1,1,0,1,0,1,0 → x=+20, y=0. Repeat with a final sign bit 1 → x=-20.
- Hold out_ready=0 for 5 cycles while axiiv=1 → axiir=0, outputs stable, no bits consumed. Then raise out_ready → the next symbol decodes correctly.
- Stream 19 zeros with no matching entry → err pulses exactly once on the 19th bit; a following 1 decodes to (0,0).
- Assert flush mid-XLIN and rst mid-CODE → next symbol decodes cleanly. After rst the table is empty: bit 1 produces no output.

Source files
------------

// File: rtl/huff_pair_decoder.sv
// Bit-serial MP3 big_values Huffman pair decoder.
// Run-time codebook, per-symbol linbits, ready/valid output.
module huff_pair_decoder #(
    parameter int MAX_BITS    = 19,
    parameter int DEPTH       = 256,
    parameter int MAX_LINBITS = 13,
    parameter int VAL_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     axiiv,
    input  logic                     axiid,
    output logic                     axiir,
    input  logic [3:0]               linbits,
    input  logic                     flush,
    input  logic                     tbl_we,
    input  logic                     tbl_clear,
    input  logic [$clog2(DEPTH)-1:0] tbl_addr,
    input  logic [4:0]               tbl_len,
    input  logic [MAX_BITS-1:0]      tbl_code,
    input  logic [3:0]               tbl_x,
    input  logic [3:0]               tbl_y,
    output logic                     axiov,
    input  logic                     out_ready,
    output logic signed [VAL_W-1:0]  x_val,
    output logic signed [VAL_W-1:0]  y_val,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int MW = MAX_LINBITS + 1;
    localparam logic [4:0] LAST = 5'(MAX_BITS - 1);

    typedef enum logic [2:0] {
        S_CODE, S_XLIN, S_XSIGN, S_YLIN, S_YSIGN, S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [4:0]             t_len  [DEPTH];
    logic [MAX_BITS-1:0]    t_code [DEPTH];
    logic [3:0]             t_x    [DEPTH];
    logic [3:0]             t_y    [DEPTH];

    logic [MAX_BITS-1:0]    code_reg;
    logic [4:0]             cnt;
    logic [3:0]             linbits_l;
    logic [MAX_LINBITS-1:0] lin_acc;
    logic [3:0]             lin_cnt;
    logic [MW-1:0]          x_mag, y_mag, x_mag_d, y_mag_d;
    logic                   x_neg, y_neg, x_neg_d, y_neg_d;

    logic                   xfer, hit, lin_last, load_out;
    logic [AW-1:0]          hit_idx;
    logic [MAX_BITS-1:0]    cand;
    logic [3:0]             lb_eff;
    logic [MAX_LINBITS-1:0] lin_new;
    logic signed [VAL_W-1:0] x_abs_v, y_abs_v;

    assign xfer     = axiiv && axiir;
    assign cand     = {code_reg[MAX_BITS-2:0], axiid};
    assign lb_eff   = (cnt == 5'd0) ? linbits : linbits_l;
    assign lin_new  = {lin_acc[MAX_LINBITS-2:0], axiid};
    assign lin_last = (lin_cnt + 4'd1) == linbits_l;
    assign load_out = (state != S_OUT) && (state_nxt == S_OUT);

    // Choose the first applicable state for the y half of a pair.
    function automatic state_t y_path(input logic [3:0] ya,
                                      input logic [3:0] lb);
        if (ya == 4'd15 && lb != 4'd0) return S_YLIN;
        else if (ya != 4'd0)           return S_YSIGN;
        else                           return S_OUT;
    endfunction

    // Choose the first applicable state after a codeword match.
    function automatic state_t x_path(input logic [3:0] xa,
                                      input logic [3:0] ya,
                                      input logic [3:0] lb);
        if (xa == 4'd15 && lb != 4'd0) return S_XLIN;
        else if (xa != 4'd0)           return S_XSIGN;
        else                           return y_path(ya, lb);
    endfunction

    // Codebook storage; clear wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst || tbl_clear) begin
            for (int i = 0; i < DEPTH; i++) t_len[i] <= '0;
        end else if (tbl_we) begin
            t_len[tbl_addr] <= tbl_len;
        end
        if (tbl_we) begin
            t_code[tbl_addr] <= tbl_code;
            t_x[tbl_addr]    <= tbl_x;
            t_y[tbl_addr]    <= tbl_y;
        end
    end

    // Parallel match of the candidate; lowest index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (t_len[i] == cnt + 5'd1 && t_code[i] == cand) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_CODE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush forces a return to CODE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_CODE:
                if (xfer && hit)
                    state_nxt = x_path(t_x[hit_idx], t_y[hit_idx], lb_eff);
            S_XLIN:
                if (xfer && lin_last) state_nxt = S_XSIGN;
            S_XSIGN:
                if (xfer) state_nxt = y_path(y_mag[3:0], linbits_l);
            S_YLIN:
                if (xfer && lin_last) state_nxt = S_YSIGN;
            S_YSIGN:
                if (xfer) state_nxt = S_OUT;
            S_OUT:
                if (out_ready) state_nxt = S_CODE;
            default:
                state_nxt = S_CODE;
        endcase
        if (flush) state_nxt = S_CODE;
    end

    // Handshake and error outputs.
    always_comb begin
        axiir = (state != S_OUT);
        axiov = (state == S_OUT);
        err   = !rst && !flush && (state == S_CODE) && xfer
                && !hit && (cnt == LAST);
    end

    // Next magnitude/sign values as each field is consumed.
    always_comb begin
        x_mag_d = x_mag;
        y_mag_d = y_mag;
        x_neg_d = x_neg;
        y_neg_d = y_neg;
        if (xfer) begin
            unique case (state)
                S_CODE: if (hit) begin
                    x_mag_d = MW'(t_x[hit_idx]);
                    y_mag_d = MW'(t_y[hit_idx]);
                    x_neg_d = 1'b0;
                    y_neg_d = 1'b0;
                end
                S_XLIN: if (lin_last) x_mag_d = MW'(15) + MW'(lin_new);
                S_XSIGN: x_neg_d = axiid;
                S_YLIN: if (lin_last) y_mag_d = MW'(15) + MW'(lin_new);
                S_YSIGN: y_neg_d = axiid;
                default: ;
            endcase
        end
        x_abs_v = VAL_W'(x_mag_d);
        y_abs_v = VAL_W'(y_mag_d);
    end

    // Datapath registers: code shifter, linbits accumulator, outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_reg  <= '0;
            cnt       <= '0;
            linbits_l <= '0;
            lin_acc   <= '0;
            lin_cnt   <= '0;
            x_mag     <= '0;
            y_mag     <= '0;
            x_neg     <= 1'b0;
            y_neg     <= 1'b0;
            x_val     <= '0;
            y_val     <= '0;
        end else if (flush) begin
            code_reg  <= '0;
            cnt       <= '0;
            linbits_l <= '0;
            lin_acc   <= '0;
            lin_cnt   <= '0;
            x_mag     <= '0;
            y_mag     <= '0;
            x_neg     <= 1'b0;
            y_neg     <= 1'b0;
        end else begin
            x_mag <= x_mag_d;
            y_mag <= y_mag_d;
            x_neg <= x_neg_d;
            y_neg <= y_neg_d;
            if (load_out) begin
                x_val <= x_neg_d ? -x_abs_v : x_abs_v;
                y_val <= y_neg_d ? -y_abs_v : y_abs_v;
            end
            if (state == S_CODE && xfer) begin
                if (cnt == 5'd0) linbits_l <= linbits;
                if (hit || cnt == LAST) begin
                    code_reg <= '0;
                    cnt      <= '0;
                end else begin
                    code_reg <= cand;
                    cnt      <= cnt + 5'd1;
                end
            end
            if ((state == S_XLIN || state == S_YLIN) && xfer) begin
                if (lin_last) begin
                    lin_acc <= '0;
                    lin_cnt <= '0;
                end else begin
                    lin_acc <= lin_new;
                    lin_cnt <= lin_cnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_huff_pair_decoder.sv
// Testbench for huff_pair_decoder.
// Directed scenarios plus random symbols against an encoder model.
module tb_huff_pair_decoder;
    logic        clk = 0;
    logic        rst = 1;
    logic        axiiv = 0, axiid = 0, axiir;
    logic [3:0]  linbits = 0;
    logic        flush = 0, tbl_we = 0, tbl_clear = 0;
    logic [7:0]  tbl_addr = 0;
    logic [4:0]  tbl_len = 0;
    logic [18:0] tbl_code = 0;
    logic [3:0]  tbl_x = 0, tbl_y = 0;
    logic        axiov, out_ready;
    logic signed [15:0] x_val, y_val;
    logic        err;

    logic force_stall = 0, bp_en = 0, mon_en = 0, rnd_bit = 1;
    int   n_checks = 0, n_pass = 0;
    int   got_x[$], got_y[$];

    huff_pair_decoder dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiir(axiir), .linbits(linbits), .flush(flush),
        .tbl_we(tbl_we), .tbl_clear(tbl_clear), .tbl_addr(tbl_addr),
        .tbl_len(tbl_len), .tbl_code(tbl_code), .tbl_x(tbl_x),
        .tbl_y(tbl_y), .axiov(axiov), .out_ready(out_ready),
        .x_val(x_val), .y_val(y_val), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= 1'($urandom);
    assign out_ready = force_stall ? 1'b0 : (bp_en ? rnd_bit : 1'b1);

    always @(negedge clk) begin
        if (mon_en && axiov && out_ready) begin
            got_x.push_back(int'(x_val));
            got_y.push_back(int'(y_val));
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; axiiv = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic tload(input int idx, input int len, input int code,
                         input int x, input int y);
        tbl_we = 1; tbl_addr = 8'(idx); tbl_len = 5'(len);
        tbl_code = 19'(code); tbl_x = 4'(x); tbl_y = 4'(y);
        @(posedge clk); #1 tbl_we = 0;
    endtask

    task automatic twipe();
        tbl_clear = 1;
        @(posedge clk); #1 tbl_clear = 0;
    endtask

    task automatic send_bit(input logic b, output logic e);
        int n = 0;
        axiiv = 1; axiid = b;
        @(negedge clk);
        while (!axiir && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!axiir) begin
            n_checks++;
            $display("FAIL send_bit timeout axiir=%b want 1", axiir);
        end
        e = err;
        @(posedge clk); #1 axiiv = 0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n,
                             output int errs);
        logic e;
        errs = 0;
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i], e);
            if (e) errs++;
        end
    endtask

    task automatic wait_pair(output int gx, output int gy,
                             output logic ok, output int lat);
        ok = 0; gx = 0; gy = 0; lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (axiov) begin
                ok = 1; gx = int'(x_val); gy = int'(y_val); lat = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (axiov !== 1'b0) $display("FAIL rst_axiov got %b want 0", axiov);
        else n_pass++;
        n_checks++;
        if (x_val !== 16'sd0 || y_val !== 16'sd0)
            $display("FAIL rst_vals got %0d,%0d want 0,0", x_val, y_val);
        else n_pass++;
        n_checks++;
        if (axiir !== 1'b1) $display("FAIL rst_axiir got %b want 1", axiir);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int e, gx, gy, lat; logic ok;
        tload(0, 1, 'b1, 0, 0);
        tload(1, 3, 'b010, 0, 1);
        tload(2, 3, 'b011, 1, 0);
        send_bits(1, 1, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || lat != 0 || gx != 0 || gy != 0 || e != 0)
            $display("FAIL basic_00 got ok=%b lat=%0d %0d,%0d err=%0d want 1 0 0,0 0",
                     ok, lat, gx, gy, e);
        else n_pass++;
        send_bits('b0111, 4, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || lat != 0 || gx != -1 || gy != 0)
            $display("FAIL basic_m10 got %b %0d %0d,%0d want 1 0 -1,0",
                     ok, lat, gx, gy);
        else n_pass++;
        send_bits('b0100, 4, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || gx != 0 || gy != 1)
            $display("FAIL basic_01 got %b %0d,%0d want 1 0,1", ok, gx, gy);
        else n_pass++;
    endtask

    task automatic test_linbits();
        int e, gx, gy, lat; logic ok;
        twipe();
        tload(7, 2, 'b11, 15, 0);
        linbits = 4;
        send_bits('b1101010, 7, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || gx != 20 || gy != 0)
            $display("FAIL lin_pos got %b %0d,%0d want 1 20,0", ok, gx, gy);
        else n_pass++;
        send_bits('b1101011, 7, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || gx != -20 || gy != 0)
            $display("FAIL lin_neg got %b %0d,%0d want 1 -20,0", ok, gx, gy);
        else n_pass++;
    endtask

    task automatic test_stall();
        int e, gx, gy, lat, bad; logic ok;
        tload(8, 1, 'b0, 0, 0);
        force_stall = 1;
        send_bits('b1101010, 7, e);
        axiiv = 1; axiid = 1; bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (axiir !== 1'b0 || axiov !== 1'b1 ||
                x_val !== 16'sd20 || y_val !== 16'sd0) bad++;
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL stall_hold got %0d bad cycles want 0", bad);
        else n_pass++;
        @(posedge clk); #1;
        force_stall = 0; axiiv = 0;
        @(negedge clk);
        n_checks++;
        if (axiov !== 1'b1 || axiir !== 1'b0)
            $display("FAIL stall_accept got v=%b r=%b want 1 0", axiov, axiir);
        else n_pass++;
        @(posedge clk); #1;
        send_bits('b0, 1, e);
        wait_pair(gx, gy, ok, lat);
        send_bits('b1101011, 7, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || gx != -20 || gy != 0)
            $display("FAIL stall_next got %b %0d,%0d want 1 -20,0",
                     ok, gx, gy);
        else n_pass++;
    endtask

    task automatic test_err();
        int e, gx, gy, lat, early; logic ok, eb;
        twipe();
        tload(0, 1, 'b1, 0, 0);
        early = 0;
        for (int i = 0; i < 18; i++) begin
            send_bit(1'b0, eb);
            if (eb) early++;
        end
        send_bit(1'b0, eb);
        n_checks++;
        if (early != 0 || eb !== 1'b1)
            $display("FAIL err_pulse got early=%0d last=%b want 0 1",
                     early, eb);
        else n_pass++;
        send_bits(1, 1, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || gx != 0 || gy != 0 || e != 0)
            $display("FAIL err_after got %b %0d,%0d e=%0d want 1 0,0 0",
                     ok, gx, gy, e);
        else n_pass++;
    endtask

    task automatic test_flush();
        int e, gx, gy, lat; logic ok;
        twipe();
        tload(3, 2, 'b11, 15, 0);
        linbits = 4;
        send_bits('b110, 3, e);
        flush = 1;
        @(posedge clk); #1 flush = 0;
        send_bits('b1101010, 7, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || gx != 20 || gy != 0)
            $display("FAIL flush_lin got %b %0d,%0d want 1 20,0", ok, gx, gy);
        else n_pass++;
        force_stall = 1;
        send_bits('b1101011, 7, e);
        flush = 1;
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        n_checks++;
        if (axiov !== 1'b0)
            $display("FAIL flush_out got axiov=%b want 0", axiov);
        else n_pass++;
        @(posedge clk); #1 force_stall = 0;
    endtask

    task automatic test_rst_mid();
        int e, gx, gy, lat, seen; logic ok;
        tload(5, 1, 'b0, 0, 0);
        send_bits(1, 1, e);
        do_reset();
        send_bits(1, 1, e);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (axiov) seen++;
        end
        n_checks++;
        if (seen != 0)
            $display("FAIL rst_table got %0d outputs want 0", seen);
        else n_pass++;
        @(posedge clk); #1;
        do_reset();
        tload(0, 1, 'b1, 0, 0);
        send_bits(1, 1, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || gx != 0 || gy != 0)
            $display("FAIL rst_next got %b %0d,%0d want 1 0,0", ok, gx, gy);
        else n_pass++;
    endtask

    task automatic test_priority();
        int e, gx, gy, lat; logic ok;
        twipe();
        tload(9, 1, 'b1, 2, 3);
        tload(4, 1, 'b1, 5, 6);
        send_bits('b101, 3, e);
        wait_pair(gx, gy, ok, lat);
        n_checks++;
        if (!ok || gx != 5 || gy != -6)
            $display("FAIL prio got %b %0d,%0d want 1 5,-6", ok, gx, gy);
        else n_pass++;
    endtask

    task automatic test_random();
        int rx[9], ry[9], exp_x[$], exp_y[$];
        int n_sym, errs, t;
        n_sym = 40; errs = 0;
        twipe();
        for (int k = 0; k < 9; k++) begin
            int len, code;
            rx[k] = ($urandom_range(0, 2) == 0) ? 15 : $urandom_range(0, 15);
            ry[k] = ($urandom_range(0, 2) == 0) ? 15 : $urandom_range(0, 15);
            len  = (k < 8) ? k + 1 : 8;
            code = (k < 8) ? (1 << len) - 2 : 255;
            tload(3 + k * 11, len, code, rx[k], ry[k]);
        end
        got_x.delete(); got_y.delete();
        mon_en = 1; bp_en = 1;
        for (int s = 0; s < n_sym; s++) begin
            logic bq[$];
            int k, lb, len, code, mag[2], ab[2];
            logic e;
            k = $urandom_range(0, 8);
            lb = $urandom_range(0, 13);
            len  = (k < 8) ? k + 1 : 8;
            code = (k < 8) ? (1 << len) - 2 : 255;
            for (int i = len - 1; i >= 0; i--) bq.push_back(code[i]);
            ab[0] = rx[k]; ab[1] = ry[k];
            for (int h = 0; h < 2; h++) begin
                mag[h] = ab[h];
                if (ab[h] == 15 && lb > 0) begin
                    int lin;
                    lin = $urandom_range(0, (1 << lb) - 1);
                    for (int i = lb - 1; i >= 0; i--) bq.push_back(lin[i]);
                    mag[h] = 15 + lin;
                end
                if (mag[h] != 0) begin
                    logic sg;
                    sg = 1'($urandom);
                    bq.push_back(sg);
                    if (sg) mag[h] = -mag[h];
                end
            end
            exp_x.push_back(mag[0]);
            exp_y.push_back(mag[1]);
            linbits = 4'(lb);
            for (int i = 0; i < bq.size(); i++) begin
                send_bit(bq[i], e);
                if (e) errs++;
                if (i == 0) linbits = 4'($urandom_range(0, 13));
            end
        end
        t = 0;
        while (got_x.size() < n_sym && t < 300) begin
            @(negedge clk);
            t++;
        end
        mon_en = 0; bp_en = 0;
        n_checks++;
        if (got_x.size() != n_sym || errs != 0)
            $display("FAIL rand_count got %0d pairs err=%0d want %0d 0",
                     got_x.size(), errs, n_sym);
        else n_pass++;
        for (int i = 0; i < n_sym && i < got_x.size(); i++) begin
            n_checks++;
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i])
                $display("FAIL rand_pair%0d got %0d,%0d want %0d,%0d",
                         i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_linbits();
        test_stall();
        test_err();
        test_flush();
        test_rst_mid();
        test_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
